// File: rtl/uart_rx_16x_pkg.sv
// Shared UART constants, state encoding and the 2-of-3 vote helper.
// Latency: none (declarations only). Backpressure: not applicable.
package uart_rx_16x_pkg;

  localparam int OS          = 16;
  localparam int DATA_BITS   = 8;
  localparam int SYNC_STAGES = 2;
  localparam int CNT_W       = $clog2(OS);
  localparam int IDX_W       = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_S7   = CNT_W'(OS/2 - 1);
  localparam logic [CNT_W-1:0] CNT_S8   = CNT_W'(OS/2);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OS/2 + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_16x_if.sv
// Receiver-side bundle: serial line in, byte/strobe/status out.
// Latency: none (wiring only). Backpressure: none, the consumer must take each strobe.
interface uart_rx_16x_if;
  import uart_rx_16x_pkg::*;

  logic                 uart_rx;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_status;
  logic                 frame_err;
  logic                 busy;

  modport master (input uart_rx, output rx_data, rx_status, frame_err, busy);
  modport slave  (output uart_rx, input rx_data, rx_status, frame_err, busy);

endinterface

// File: rtl/uart_rx_16x_bit_sampler.sv
// Synchronises the line, times bit cells and majority-votes samples at ticks 7/8/9.
// Latency: SYNC_STAGES cycles to rx_s; vote valid in the mid cycle. Backpressure: none.
module uart_rx_16x_bit_sampler
  import uart_rx_16x_pkg::*;
(
  input  logic clk16,
  input  logic reset,
  input  logic uart_rx,
  input  logic run,
  input  logic clr,
  output logic rx_s,
  output logic vote,
  output logic mid,
  output logic last
);

  logic [SYNC_STAGES-1:0] sync;
  logic [CNT_W-1:0]       cnt;
  logic                   s7;
  logic                   s8;

  // Synchroniser resets to the idle-high line level so reset never fakes a start bit.
  always_ff @(posedge clk16 or negedge reset) begin
    if (!reset) begin
      sync <= '1;
      cnt  <= '0;
      s7   <= 1'b0;
      s8   <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], uart_rx};
      if (clr)
        cnt <= '0;
      else if (run)
        cnt <= last ? '0 : cnt + 1'b1;
      if (run && cnt == CNT_S7)
        s7 <= rx_s;
      if (run && cnt == CNT_S8)
        s8 <= rx_s;
    end
  end

  assign rx_s = sync[SYNC_STAGES-1];
  assign mid  = (cnt == CNT_MID);
  assign last = (cnt == CNT_LAST);
  assign vote = majority3(s7, s8, rx_s);

endmodule

// File: rtl/uart_rx_16x.sv
// 8N1 receiver at 16x oversampling: byte with one-cycle rx_status, or one-cycle frame_err.
// Latency: strobe 157 clk16 edges after the start bit is first sampled. Backpressure: none.
module uart_rx_16x
  import uart_rx_16x_pkg::*;
(
  input logic           clk16,
  input logic           reset,
  uart_rx_16x_if.master bus
);

  rx_state_t            state;
  rx_state_t            state_nxt;
  logic [IDX_W-1:0]     idx;
  logic [IDX_W-1:0]     idx_nxt;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] shift_nxt;
  logic [DATA_BITS-1:0] data_q;
  logic [DATA_BITS-1:0] data_nxt;
  logic                 status_q;
  logic                 status_nxt;
  logic                 ferr_q;
  logic                 ferr_nxt;
  logic                 busy_q;

  logic rx_s;
  logic vote;
  logic mid;
  logic last;
  logic run;
  logic clr;

  uart_rx_16x_bit_sampler u_sampler (
    .clk16   (clk16),
    .reset   (reset),
    .uart_rx (bus.uart_rx),
    .run     (run),
    .clr     (clr),
    .rx_s    (rx_s),
    .vote    (vote),
    .mid     (mid),
    .last    (last)
  );

  always_ff @(posedge clk16 or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      idx      <= '0;
      shift    <= '0;
      data_q   <= '0;
      status_q <= 1'b0;
      ferr_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      shift    <= shift_nxt;
      data_q   <= data_nxt;
      status_q <= status_nxt;
      ferr_q   <= ferr_nxt;
      busy_q   <= (state_nxt != IDLE);
    end
  end

  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    shift_nxt  = shift;
    data_nxt   = data_q;
    status_nxt = 1'b0;
    ferr_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s)
          state_nxt = START;
      end
      START: begin
        // A start bit that votes high at mid-cell was line noise.
        if (mid && vote)
          state_nxt = IDLE;
        else if (last) begin
          state_nxt = DATA;
          idx_nxt   = '0;
        end
      end
      DATA: begin
        if (mid)
          shift_nxt[idx] = vote;
        if (last) begin
          idx_nxt = idx + 1'b1;
          if (idx == IDX_LAST)
            state_nxt = STOP;
        end
      end
      STOP: begin
        // Decide at mid-cell and leave early so a zero-gap next start bit is caught.
        if (mid) begin
          if (vote) begin
            data_nxt   = shift;
            status_nxt = 1'b1;
            state_nxt  = IDLE;
          end else begin
            ferr_nxt   = 1'b1;
            state_nxt  = BREAK;
          end
        end
      end
      BREAK: begin
        if (rx_s)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign run = (state == START) || (state == DATA) || (state == STOP);
  assign clr = (state_nxt != state);

  assign bus.rx_data   = data_q;
  assign bus.rx_status = status_q;
  assign bus.frame_err = ferr_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_16x.sv
// Randomised frame stimulus with a queue scoreboard checked by an independent strobe monitor.
module tb_uart_rx_16x;
  import uart_rx_16x_pkg::*;

  logic clk16 = 1'b0;
  logic reset;

  uart_rx_16x_if bus();

  uart_rx_16x dut (
    .clk16 (clk16),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk16 = ~clk16;

  int cyc = 0;
  always @(posedge clk16) cyc <= cyc + 1;

  typedef struct {
    bit         ferr;
    logic [7:0] val;
    int         at;
  } exp_t;

  exp_t       sb[$];
  exp_t       m_e;
  int         tests = 0;
  int         fails = 0;
  logic [7:0] good  = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every strobe must match the oldest expected event.
  always @(negedge clk16) begin
    if (reset === 1'b1 && (bus.rx_status || bus.frame_err)) begin
      if (sb.size() == 0) begin
        chk("unexpected_strobe", {30'd0, bus.rx_status, bus.frame_err}, 32'd0);
      end else begin
        m_e = sb.pop_front();
        chk("strobe_kind", {30'd0, bus.rx_status, bus.frame_err}, m_e.ferr ? 32'd1 : 32'd2);
        chk("rx_data", {24'd0, bus.rx_data}, {24'd0, m_e.val});
        if (m_e.at >= 0)
          chk("strobe_cycle", cyc, m_e.at);
      end
    end
  end

  // Caller keeps the task starting 1 time unit after a rising edge.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int bit_t,
                            input bit noise, input bit timed);
    int off;
    off = bit_t * 95 / 160;
    if (stop_bit) begin
      sb.push_back('{1'b0, d, timed ? cyc + 157 : -1});
      good = d;
    end else begin
      sb.push_back('{1'b1, good, timed ? cyc + 157 : -1});
    end
    bus.uart_rx = 1'b0;
    #(bit_t);
    for (int i = 0; i < DATA_BITS; i++) begin
      bus.uart_rx = d[i];
      if (noise) begin
        #(off);
        bus.uart_rx = ~d[i];
        #8;
        bus.uart_rx = d[i];
        #(bit_t - off - 8);
      end else begin
        #(bit_t);
      end
    end
    bus.uart_rx = stop_bit;
    #(bit_t);
  endtask

  initial begin
    logic [7:0] d;
    logic       st;
    int         gap;

    bus.uart_rx = 1'b1;
    reset       = 1'b0;
    #23;
    chk("rst_rx_data",   {24'd0, bus.rx_data}, 32'd0);
    chk("rst_rx_status", {31'd0, bus.rx_status}, 32'd0);
    chk("rst_frame_err", {31'd0, bus.frame_err}, 32'd0);
    chk("rst_busy",      {31'd0, bus.busy}, 32'd0);
    reset = 1'b1;
    @(posedge clk16);
    #1;
    #100;

    send_frame(8'hA5, 1'b1, 160, 1'b0, 1'b1);
    bus.uart_rx = 1'b1;
    #100;

    send_frame(8'h00, 1'b1, 160, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b1, 160, 1'b0, 1'b1);
    send_frame(8'h3C, 1'b1, 160, 1'b0, 1'b1);
    bus.uart_rx = 1'b1;
    #100;

    // 3-tick glitch: START at edge 3, rejected at edge 13.
    bus.uart_rx = 1'b0;
    #30;
    bus.uart_rx = 1'b1;
    repeat (9) @(posedge clk16);
    @(negedge clk16);
    chk("glitch_busy_e12", {31'd0, bus.busy}, 32'd1);
    @(negedge clk16);
    chk("glitch_busy_e13", {31'd0, bus.busy}, 32'd0);
    @(posedge clk16);
    #1;
    #200;

    send_frame(8'h5A, 1'b0, 160, 1'b0, 1'b1);
    bus.uart_rx = 1'b1;
    #100;

    // Held-low line: one frame error, busy until released.
    sb.push_back('{1'b1, good, cyc + 157});
    bus.uart_rx = 1'b0;
    #(40 * 160);
    chk("break_busy_low", {31'd0, bus.busy}, 32'd1);
    bus.uart_rx = 1'b1;
    #50;
    chk("break_busy_released", {31'd0, bus.busy}, 32'd0);
    #50;
    send_frame(8'h81, 1'b1, 160, 1'b0, 1'b1);
    bus.uart_rx = 1'b1;
    #100;

    // Reset in the middle of data bit 4 of 0xC3.
    d = 8'hC3;
    bus.uart_rx = 1'b0;
    #160;
    for (int i = 0; i < 4; i++) begin
      bus.uart_rx = d[i];
      #160;
    end
    bus.uart_rx = d[4];
    #80;
    chk("abort_busy_before", {31'd0, bus.busy}, 32'd1);
    reset = 1'b0;
    #1;
    chk("abort_rx_data",   {24'd0, bus.rx_data}, 32'd0);
    chk("abort_rx_status", {31'd0, bus.rx_status}, 32'd0);
    chk("abort_frame_err", {31'd0, bus.frame_err}, 32'd0);
    chk("abort_busy",      {31'd0, bus.busy}, 32'd0);
    good = 8'h00;
    #30;
    bus.uart_rx = 1'b1;
    reset = 1'b1;
    @(posedge clk16);
    #1;
    #100;
    send_frame(8'h96, 1'b1, 160, 1'b0, 1'b1);
    bus.uart_rx = 1'b1;
    #100;

    for (int n = 0; n < 10; n++) begin
      d   = 8'($urandom);
      st  = ($urandom_range(0, 3) != 0);
      gap = st ? $urandom_range(0, 4) : $urandom_range(2, 6);
      send_frame(d, st, 160, 1'b0, 1'b1);
      bus.uart_rx = 1'b1;
      #(gap * 10);
    end
    #100;

    // +-3% bit period with a one-tick noise spike near the mid sample of every data bit.
    send_frame(8'h69, 1'b1, 165, 1'b1, 1'b0);
    bus.uart_rx = 1'b1;
    #30;
    send_frame(8'h69, 1'b1, 155, 1'b1, 1'b0);
    bus.uart_rx = 1'b1;
    #30;
    for (int n = 0; n < 4; n++) begin
      d = 8'($urandom);
      send_frame(d, 1'b1, (n % 2 == 0) ? 165 : 155, 1'b1, 1'b0);
      bus.uart_rx = 1'b1;
      #30;
    end

    for (int i = 0; i < 2000 && sb.size() != 0; i++)
      @(posedge clk16);
    chk("scoreboard_drained", sb.size(), 32'd0);
    #1;
    chk("final_rx_data", {24'd0, bus.rx_data}, {24'd0, good});
    chk("final_busy", {31'd0, bus.busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached with %0d events pending", sb.size());
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

endmodule
